// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers used by both write- and read-side controllers.
// Pure functions, no state; combinational when inlined into callers.
// No flow control of its own.
package fifo_pkg;

   // Widest pointer the helpers handle; callers zero-extend narrower pointers.
   localparam int PTR_MAX = 32;

   // Pointer width for a given depth: address bits plus one wrap bit.
   function automatic int ptr_w(input int d);
      return $clog2(d) + 1;
   endfunction

   // Binary to reflected-gray; upper zero bits stay zero, so any width works.
   function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
      logic [PTR_MAX-1:0] b;
      b = '0;
      for (int i = 0; i < PTR_MAX; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side pointer/flag controller (write clock domain only).
// Latency: pointer, address and flags update on the edge that samples wr_en.
// Backpressure: writes are refused while wfull; a refused write sets sticky wovf.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int depth     = 1024,
   parameter int AF_THRESH = depth - 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     wclr_ovf,
   input  logic [ptr_w(depth)-1:0]  wq2_rptr,
   output logic [$clog2(depth)-1:0] waddr,
   output logic                     wram_we,
   output logic [ptr_w(depth)-1:0]  wptr,
   output logic                     wfull,
   output logic                     walmost_full,
   output logic [ptr_w(depth)-1:0]  wlevel,
   output logic                     wovf
);

   localparam int AW = $clog2(depth);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rbin;
   logic [PW-1:0] level_next;
   logic [PW-1:0] full_ptr;
   logic          push;

   // Next-pointer, level and full-compare values, evaluated every cycle so flags
   // track the synchronized read pointer even when nothing is written.
   always_comb begin
      push       = wr_en && !wfull;
      wbin_next  = push ? wbin + PW'(1) : wbin;
      wgray_next = PW'(bin2gray(PTR_MAX'(wbin_next)));
      rbin       = PW'(gray2bin(PTR_MAX'(wq2_rptr)));
      level_next = wbin_next - rbin;
      // Full when write pointer is exactly one lap ahead: top two gray bits inverted.
      full_ptr   = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};
   end

   // RAM strobe is combinational so data lands at waddr on the accepting edge.
   assign wram_we = push && !rst;
   assign waddr   = wbin[AW-1:0];

   // Pointer, flag and level registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wfull        <= (wgray_next == full_ptr);
         walmost_full <= (level_next >= AF_T);
         wlevel       <= level_next;
         // A refused write outranks a clear in the same cycle.
         if (wr_en && wfull) begin
            wovf <= 1'b1;
         end else if (wclr_ovf) begin
            wovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl at depth 8, almost-full threshold 6.
// Reference model counts total writes and reads as integers.
// Directed scenarios first, then randomized writes, reads, clears and resets.
module tb_fifo_wr_ctrl;

   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       wclr_ovf = 1'b0;
   logic [3:0] wq2_rptr = '0;
   logic [2:0] waddr;
   logic       wram_we;
   logic [3:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       wovf;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: totals since the last reset.
   int  m_wtot = 0;
   int  m_rtot = 0;
   bit  m_full = 0;
   bit  m_ovf  = 0;

   fifo_wr_ctrl #(.depth(DEPTH), .AF_THRESH(AF)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wclr_ovf     (wclr_ovf),
      .wq2_rptr     (wq2_rptr),
      .waddr        (waddr),
      .wram_we      (wram_we),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gray4(input int n);
      int m;
      m = n % 16;
      return 4'(m ^ (m >> 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: apply inputs, check the combinational strobe, clock, then check
   // every registered output against the integer-count model.
   task automatic cycle(input bit r, input bit we, input bit cl, input int rd);
      int lvl;
      bit was_full;
      rst = r; wr_en = we; wclr_ovf = cl;
      m_rtot = rd;
      wq2_rptr = gray4(rd);
      #1;
      chk("wram_we", {31'b0, wram_we}, {31'b0, (!r && we && !m_full)});
      if (!r) chk("waddr_pre", {29'b0, waddr}, 32'(m_wtot % DEPTH));
      @(posedge clk); #1;
      was_full = m_full;
      if (r) begin
         m_wtot = 0; m_ovf = 0; lvl = 0;
      end else begin
         if (we && !was_full) m_wtot++;
         lvl = m_wtot - m_rtot;
         if (we && was_full) m_ovf = 1;
         else if (cl) m_ovf = 0;
      end
      m_full = (lvl == DEPTH);
      chk("wptr",   {28'b0, wptr},   {28'b0, gray4(m_wtot)});
      chk("waddr",  {29'b0, waddr},  32'(m_wtot % DEPTH));
      chk("wfull",  {31'b0, wfull},  {31'b0, m_full});
      chk("walmost_full", {31'b0, walmost_full}, {31'b0, (lvl >= AF)});
      chk("wlevel", {28'b0, wlevel}, 32'(lvl));
      chk("wovf",   {31'b0, wovf},   {31'b0, m_ovf});
   endtask

   initial begin
      logic [3:0] fill_seq [8];
      fill_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

      // Reset held two cycles with a write pending.
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      chk("rst_wptr", {28'b0, wptr}, 32'd0);
      chk("rst_wlevel", {28'b0, wlevel}, 32'd0);

      // Fill eight back-to-back.
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, 0);
         chk("fill_seq", {28'b0, wptr}, {28'b0, fill_seq[i]});
         chk("fill_af", {31'b0, walmost_full}, {31'b0, (i >= 5)});
      end
      chk("fill_full", {31'b0, wfull}, 32'd1);
      chk("fill_level", {28'b0, wlevel}, 32'd8);

      // Overflow, then a lone clear.
      cycle(0, 1, 0, 0);
      chk("ovf_wptr", {28'b0, wptr}, 32'hC);
      chk("ovf_waddr", {29'b0, waddr}, 32'd0);
      chk("ovf_set", {31'b0, wovf}, 32'd1);
      cycle(0, 0, 1, 0);
      chk("ovf_clr", {31'b0, wovf}, 32'd0);

      // Drain three, then wrap with three more writes.
      cycle(0, 0, 0, 3);
      chk("drain_full", {31'b0, wfull}, 32'd0);
      chk("drain_level", {28'b0, wlevel}, 32'd5);
      chk("drain_af", {31'b0, walmost_full}, 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 3);
      chk("wrap_wptr", {28'b0, wptr}, 32'hE);
      chk("wrap_full", {31'b0, wfull}, 32'd1);
      chk("wrap_waddr", {29'b0, waddr}, 32'd3);

      // Set beats clear in the same cycle.
      cycle(0, 1, 1, 3);
      chk("setclr_ovf", {31'b0, wovf}, 32'd1);
      cycle(0, 0, 1, 3);

      // Mid-operation reset at level 5.
      cycle(0, 0, 0, 6);
      chk("mid_level", {28'b0, wlevel}, 32'd5);
      cycle(1, 1, 0, 6);
      chk("mid_rst_wptr", {28'b0, wptr}, 32'd0);
      chk("mid_rst_level", {28'b0, wlevel}, 32'd0);
      cycle(0, 1, 0, 0);
      chk("post_rst_wptr", {28'b0, wptr}, 32'd1);

      // Randomized traffic; reads never pass the current write total.
      for (int n = 0; n < 400; n++) begin
         bit r, we, cl;
         int rd;
         r  = ($urandom_range(0, 99) < 2);
         we = ($urandom_range(0, 99) < 65);
         cl = ($urandom_range(0, 99) < 10);
         rd = m_rtot;
         if ($urandom_range(0, 99) < 40 && m_wtot > m_rtot)
            rd = m_rtot + $urandom_range(1, m_wtot - m_rtot);
         cycle(r, we, cl, rd);
         if (r) m_rtot = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
